// File: rtl/hs_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : hs_tx_pkg                                                  |
// | Description : Shared types and default constants for the hs_tx_source    |
// |               valid/ready initiator and its FIFO.                        |
// |               - hs_tx_state_e : handshake FSM state (IDLE/ACTIVE)        |
// |               - c_data_w, c_depth, c_stall_max : parameter defaults      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package hs_tx_pkg;

   localparam int unsigned c_data_w    = 8;
   localparam int unsigned c_depth     = 4;
   localparam int unsigned c_stall_max = 16;

   // IDLE: nothing offered (valid=0). ACTIVE: a beat is offered (valid=1).
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } hs_tx_state_e;

endpackage : hs_tx_pkg
`default_nettype wire

// File: rtl/hs_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hs_tx_fifo                                                 |
// | Description : Register-based FIFO feeding the hs_tx_source initiator.    |
// |               The head entry is read combinationally so it can drive     |
// |               the downstream data bus directly.                          |
// | Ports       : clk      in   clock, rising edge                           |
// |               rst_n    in   asynchronous active-low reset                |
// |               push     in   write wr_data (caller guarantees !full)      |
// |               pop      in   advance head  (caller guarantees level!=0)   |
// |               wr_data  in   DATA_W  entry to write                       |
// |               rd_data  out  DATA_W  current head entry                   |
// |               level    out  occupancy, 0..DEPTH                          |
// |               full     out  level == DEPTH                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hs_tx_fifo
   import hs_tx_pkg::*;
#(
   parameter int unsigned DATA_W = c_data_w,
   parameter int unsigned DEPTH  = c_depth
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          wr_data,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   // DEPTH is a power of two, so the natural roll-over of the pointer
   // width gives the DEPTH-1 -> 0 wrap without an explicit compare.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push && pop) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset: an entry is only visible once level covers it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;
   assign full    = (level_q == LVL_W'(DEPTH));

endmodule : hs_tx_fifo
`default_nettype wire

// File: rtl/hs_tx_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hs_tx_source                                               |
// | Description : Initiator side of a valid/ready handshake. A producer      |
// |               pushes beats into a small FIFO; the block offers the FIFO  |
// |               head downstream and holds valid/data until ready.          |
// | Ports       : clk        in   clock, rising edge                         |
// |               rst_n      in   asynchronous active-low reset              |
// |               tx_en      in   permit start of a new beat                 |
// |               wr_en      in   push wr_data (dropped while full)          |
// |               wr_data    in   DATA_W push data                           |
// |               full       out  FIFO holds DEPTH entries                   |
// |               level      out  FIFO occupancy                             |
// |               valid      out  beat offered downstream                    |
// |               ready      in   downstream accepts                         |
// |               data       out  DATA_W beat payload (FIFO head)            |
// |               stall_err  out  sticky stall watchdog flag                 |
// | Config      : HS_TX_STALL_WDOG_EN - builds the stall watchdog; when      |
// |               undefined stall_err is tied low. Ports are identical.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hs_tx_source
   import hs_tx_pkg::*;
#(
   parameter int unsigned DATA_W    = c_data_w,
   parameter int unsigned DEPTH     = c_depth,
   parameter int unsigned STALL_MAX = c_stall_max
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tx_en,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       valid,
   input  logic                       ready,
   output logic [DATA_W-1:0]          data,
   output logic                       stall_err
);

   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   hs_tx_state_e state_q, state_d;
   logic         push;
   logic         pop;
   logic         more_after_pop;

   // full is the pre-pop view, so a write that coincides with a pop while
   // full is still dropped.
   assign push = wr_en && !full;
   assign pop  = valid && ready;

   hs_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .rd_data (data),
      .level   (level),
      .full    (full)
   );

   // (level - 1 + push) != 0, written without the subtraction; only used
   // in ACTIVE where level >= 1.
   assign more_after_pop = (level > LVL_W'(1)) || push;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // Counting the same-cycle push gives a one-clock push-to-valid path.
            if (tx_en && ((level != '0) || push)) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // An offered beat is never withdrawn; tx_en only gates the next one.
            if (ready) begin
               state_d = (tx_en && more_after_pop) ? ACTIVE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign valid = (state_q == ACTIVE);

`ifdef HS_TX_STALL_WDOG_EN
   localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stall_err_q, stall_err_d;

   // Counts consecutive offered-but-not-accepted cycles, saturating at
   // STALL_MAX; any handshake or idle cycle restarts it.
   always_comb begin
      stall_cnt_d = '0;
      if (valid && !ready) begin
         stall_cnt_d = (stall_cnt_q == CNT_W'(STALL_MAX)) ? stall_cnt_q
                                                          : stall_cnt_q + CNT_W'(1);
      end
      stall_err_d = stall_err_q || (stall_cnt_d == CNT_W'(STALL_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign stall_err = stall_err_q;
`else
   assign stall_err = 1'b0;
`endif

endmodule : hs_tx_source
`default_nettype wire

// File: tb/tb_hs_tx_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hs_tx_source                                            |
// | Description : Self-checking bench for hs_tx_source. Directed scenarios   |
// |               plus a randomized run against a queue-based model of the   |
// |               handshake rules. Honours HS_TX_STALL_WDOG_EN.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hs_tx_source;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 4;
   localparam int STALL_MAX = 16;
   localparam int LVL_W     = $clog2(DEPTH + 1);

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              tx_en   = 1'b0;
   logic              wr_en   = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              ready   = 1'b0;
   logic              full;
   logic [LVL_W-1:0]  level;
   logic              valid;
   logic [DATA_W-1:0] data;
   logic              stall_err;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: queue of pending beats, offered flag, stall run.
   logic [DATA_W-1:0] q[$];
   bit                m_valid;
   int                m_stall;
   bit                m_err;

   hs_tx_source #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .STALL_MAX (STALL_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en     (tx_en),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .level     (level),
      .valid     (valid),
      .ready     (ready),
      .data      (data),
      .stall_err (stall_err)
   );

   always #5 clk = ~clk;

   function automatic bit exp_err();
`ifdef HS_TX_STALL_WDOG_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_valid = 1'b0;
      m_stall = 0;
      m_err   = 1'b0;
   endtask

   // One clock of the protocol: beat accepted when offered and ready,
   // write accepted when not full (judged before the pop), an offered beat
   // stays offered until ready, otherwise a beat is offered when enabled
   // and something is queued.
   task automatic model_step(input bit te, input bit we, input logic [DATA_W-1:0] wd,
                             input bit rd);
      bit hs, stall, pu;
      hs    = m_valid && rd;
      stall = m_valid && !rd;
      pu    = we && (q.size() < DEPTH);
      if (hs) void'(q.pop_front());
      if (pu) q.push_back(wd);
      if (stall) begin
         if (m_stall < STALL_MAX) m_stall++;
         if (m_stall == STALL_MAX) m_err = 1'b1;
      end else begin
         m_stall = 0;
      end
      m_valid = stall ? 1'b1 : (te && q.size() != 0);
   endtask

   task automatic cyc(input bit te, input bit we, input logic [DATA_W-1:0] wd, input bit rd);
      tx_en   = te;
      wr_en   = we;
      wr_data = wd;
      ready   = rd;
      @(posedge clk);
      model_step(te, we, wd, rd);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tx_en = 1'b0; wr_en = 1'b0; ready = 1'b0; wr_data = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; ready = 1'b1;
      model_reset();
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL reset_stall_err got=%b exp=0", stall_err); end
      tx_en = 1'b0; wr_en = 1'b0; ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_beat();
      cyc(1, 1, 8'hA5, 0);
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL t1_first_valid got=%b exp=1", valid); end
      checks++; if (data !== 8'hA5) begin failures++; $display("FAIL t1_first_data got=%h exp=a5", data); end
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 8'h00, 0);
         checks++; if (valid !== 1'b1 || data !== 8'hA5) begin
            failures++; $display("FAIL t1_hold%0d got valid=%b data=%h exp valid=1 data=a5", k, valid, data);
         end
      end
      cyc(1, 0, 8'h00, 1);
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t1_after_pop_valid got=%b exp=0", valid); end
      checks++; if (level !== '0) begin failures++; $display("FAIL t1_after_pop_level got=%0d exp=0", level); end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 4; k++) begin
         logic [DATA_W-1:0] v;
         v = DATA_W'(k);
         cyc(1, 1, v, 1);
         checks++; if (valid !== 1'b1 || data !== v) begin
            failures++; $display("FAIL b2b_beat%0d got valid=%b data=%h exp valid=1 data=%h", k, valid, data, v);
         end
      end
      cyc(1, 0, 8'h00, 1);
      checks++; if (valid !== 1'b0 || level !== '0) begin
         failures++; $display("FAIL b2b_end got valid=%b level=%0d exp valid=0 level=0", valid, level);
      end
   endtask

   task automatic test_full_drop();
      for (int k = 0; k < 4; k++) cyc(1, 1, 8'h10 + DATA_W'(k), 0);
      checks++; if (full !== 1'b1 || level !== LVL_W'(4)) begin
         failures++; $display("FAIL full_set got full=%b level=%0d exp full=1 level=4", full, level);
      end
      cyc(1, 1, 8'hFF, 0);
      checks++; if (level !== LVL_W'(4)) begin failures++; $display("FAIL full_drop_level got=%0d exp=4", level); end
      for (int k = 0; k < 4; k++) begin
         logic [DATA_W-1:0] v;
         v = 8'h10 + DATA_W'(k);
         checks++; if (valid !== 1'b1 || data !== v) begin
            failures++; $display("FAIL full_drain%0d got valid=%b data=%h exp valid=1 data=%h", k, valid, data, v);
         end
         cyc(1, 0, 8'h00, 1);
      end
      checks++; if (valid !== 1'b0 || level !== '0) begin
         failures++; $display("FAIL full_drain_end got valid=%b level=%0d exp valid=0 level=0", valid, level);
      end
   endtask

   task automatic test_tx_en_drop();
      cyc(1, 1, 8'h20, 0);
      cyc(1, 1, 8'h21, 0);
      cyc(1, 1, 8'h22, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 8'h00, 0);
         checks++; if (valid !== 1'b1 || data !== 8'h20) begin
            failures++; $display("FAIL txen_hold%0d got valid=%b data=%h exp valid=1 data=20", k, valid, data);
         end
      end
      cyc(0, 0, 8'h00, 1);
      checks++; if (valid !== 1'b0 || level !== LVL_W'(2)) begin
         failures++; $display("FAIL txen_withhold got valid=%b level=%0d exp valid=0 level=2", valid, level);
      end
      cyc(0, 0, 8'h00, 1);
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL txen_withhold2 got=%b exp=0", valid); end
      cyc(1, 0, 8'h00, 0);
      checks++; if (valid !== 1'b1 || data !== 8'h21) begin
         failures++; $display("FAIL txen_resume got valid=%b data=%h exp valid=1 data=21", valid, data);
      end
      cyc(1, 0, 8'h00, 1);
      checks++; if (valid !== 1'b1 || data !== 8'h22) begin
         failures++; $display("FAIL txen_next got valid=%b data=%h exp valid=1 data=22", valid, data);
      end
      cyc(1, 0, 8'h00, 1);
      checks++; if (valid !== 1'b0 || level !== '0) begin
         failures++; $display("FAIL txen_end got valid=%b level=%0d exp valid=0 level=0", valid, level);
      end
   endtask

   task automatic test_reset_mid_beat();
      cyc(1, 1, 8'h30, 0);
      cyc(1, 1, 8'h31, 0);
      cyc(1, 1, 8'h32, 0);
      checks++; if (valid !== 1'b1 || level !== LVL_W'(3)) begin
         failures++; $display("FAIL midrst_pre got valid=%b level=%0d exp valid=1 level=3", valid, level);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (valid !== 1'b0 || level !== '0 || full !== 1'b0) begin
         failures++; $display("FAIL midrst_async got valid=%b level=%0d full=%b exp 0/0/0", valid, level, full);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 8'h00, 1);
         checks++; if (valid !== 1'b0 || level !== '0) begin
            failures++; $display("FAIL midrst_stale%0d got valid=%b level=%0d exp valid=0 level=0", k, valid, level);
         end
      end
      cyc(1, 1, 8'h5A, 0);
      checks++; if (valid !== 1'b1 || data !== 8'h5A) begin
         failures++; $display("FAIL midrst_fresh got valid=%b data=%h exp valid=1 data=5a", valid, data);
      end
      cyc(1, 0, 8'h00, 1);
   endtask

   task automatic test_watchdog();
      bit e;
      apply_reset();
      cyc(1, 1, 8'h77, 0);
      for (int k = 1; k <= STALL_MAX; k++) begin
         cyc(1, 0, 8'h00, 0);
`ifdef HS_TX_STALL_WDOG_EN
         e = (k >= STALL_MAX);
`else
         e = 1'b0;
`endif
         checks++; if (stall_err !== e) begin
            failures++; $display("FAIL wdog_stall%0d got=%b exp=%b", k, stall_err, e);
         end
      end
      cyc(1, 0, 8'h00, 1);
`ifdef HS_TX_STALL_WDOG_EN
      e = 1'b1;
`else
      e = 1'b0;
`endif
      checks++; if (stall_err !== e || valid !== 1'b0) begin
         failures++; $display("FAIL wdog_sticky got err=%b valid=%b exp err=%b valid=0", stall_err, valid, e);
      end
      apply_reset();
      #1;
      checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL wdog_clear got=%b exp=0", stall_err); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         bit te, we, rd;
         logic [DATA_W-1:0] wd;
         te = ($urandom_range(0, 7) != 0);
         we = ($urandom_range(0, 2) != 0);
         wd = DATA_W'($urandom);
         rd = ((i % 150) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
         cyc(te, we, wd, rd);
         checks++; if (valid !== m_valid) begin
            failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, valid, m_valid);
         end
         checks++; if (level !== LVL_W'(q.size())) begin
            failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, q.size());
         end
         checks++; if (full !== (q.size() == DEPTH)) begin
            failures++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", i, full, (q.size() == DEPTH));
         end
         if (m_valid) begin
            checks++; if (data !== q[0]) begin
               failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, data, q[0]);
            end
         end
         checks++; if (stall_err !== exp_err()) begin
            failures++; $display("FAIL rand_stall_err cyc=%0d got=%b exp=%b", i, stall_err, exp_err());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_full_drop();
      test_tx_en_drop();
      test_reset_mid_beat();
      test_watchdog();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_hs_tx_source
`default_nettype wire
